// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared states, neighbour offsets and index-width helper for the reveal engine
package minesweeper_pkg;

    // Flood-fill sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_EVAL,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Neighbour offsets indexed by nb: NW, N, NE, W, E, SW, S, SE
    localparam int NB_DROW [0:7] = '{-1, -1, -1,  0, 0,  1, 1, 1};
    localparam int NB_DCOL [0:7] = '{-1,  0,  1, -1, 1, -1, 0, 1};

    // Width of a cell index for a square board of the given edge length
    function automatic int cell_idx_w(input int grid_size);
        return (grid_size * grid_size > 1) ? $clog2(grid_size * grid_size) : 1;
    endfunction

endpackage

// File: rtl/adj_bomb_count.sv
// rtl/adj_bomb_count.sv - combinational count of bombs among the in-bounds 8-neighbours of a cell
module adj_bomb_count
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE = 9,
    parameter int IDX_W     = cell_idx_w(GRID_SIZE)
) (
    input  logic [IDX_W-1:0]               cur,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] bomb_grid,
    output logic [3:0]                     count
);

    int               row;
    int               col;
    int               nrow;
    int               ncol;
    logic [IDX_W-1:0] nidx;

    // Walk the eight offsets; rows and columns are range-checked separately so col 0 never sees col GRID_SIZE-1
    always_comb begin
        count = 4'd0;
        row   = int'(cur) / GRID_SIZE;
        col   = int'(cur) % GRID_SIZE;
        nrow  = 0;
        ncol  = 0;
        nidx  = '0;
        for (int k = 0; k < 8; k++) begin
            nrow = row + NB_DROW[k];
            ncol = col + NB_DCOL[k];
            if (nrow >= 0 && nrow < GRID_SIZE && ncol >= 0 && ncol < GRID_SIZE) begin
                nidx = IDX_W'(nrow * GRID_SIZE + ncol);
                if (bomb_grid[nidx]) begin
                    count = count + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/reveal_sequencer.sv
// rtl/reveal_sequencer.sv - flood-fill reveal engine owning reveal_grid; optional win flag under MINES_WIN_DETECT_EN
module reveal_sequencer
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE = 9,
    parameter int IDX_W     = cell_idx_w(GRID_SIZE)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [IDX_W-1:0]               start_idx,
    input  logic                           clear,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] bomb_grid,
    output logic [GRID_SIZE*GRID_SIZE-1:0] reveal_grid,
    output logic                           busy,
    output logic                           done,
    output logic                           hit_bomb
`ifdef MINES_WIN_DETECT_EN
   ,output logic                           win
`endif
);

    localparam int N  = GRID_SIZE * GRID_SIZE;
    localparam int CW = IDX_W + 1;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] stack_mem [0:N-1];
    logic [CW-1:0]    sp;
    logic [IDX_W-1:0] sp_top;
    logic [N-1:0]     queued;
    logic [IDX_W-1:0] cur;
    logic [2:0]       nb;
    logic [3:0]       adj_cnt;

    int               cur_row;
    int               cur_col;
    int               nb_row;
    int               nb_col;
    logic             nb_in;
    logic [IDX_W-1:0] nb_idx;
    logic             scan_push;
    logic             start_push;
    logic             push_en;
    logic [IDX_W-1:0] push_idx;

    assign sp_top = IDX_W'(sp - CW'(1));

    adj_bomb_count #(
        .GRID_SIZE (GRID_SIZE),
        .IDX_W     (IDX_W)
    ) u_adj (
        .cur       (cur),
        .bomb_grid (bomb_grid),
        .count     (adj_cnt)
    );

    // Locate the current SCAN neighbour and decide whether anything is pushed this cycle
    always_comb begin
        cur_row    = int'(cur) / GRID_SIZE;
        cur_col    = int'(cur) % GRID_SIZE;
        nb_row     = cur_row + NB_DROW[nb];
        nb_col     = cur_col + NB_DCOL[nb];
        nb_in      = (nb_row >= 0) && (nb_row < GRID_SIZE) && (nb_col >= 0) && (nb_col < GRID_SIZE);
        nb_idx     = nb_in ? IDX_W'(nb_row * GRID_SIZE + nb_col) : '0;
        scan_push  = (state == ST_SCAN) && nb_in && !reveal_grid[nb_idx]
                     && !queued[nb_idx] && !bomb_grid[nb_idx];
        start_push = (state == ST_IDLE) && !clear && start
                     && !reveal_grid[start_idx] && !bomb_grid[start_idx];
        push_en    = start_push || scan_push;
        push_idx   = start_push ? start_idx : nb_idx;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus busy/done
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!clear && start) begin
                    state_next = (reveal_grid[start_idx] || bomb_grid[start_idx]) ? ST_DONE : ST_POP;
                end
            end
            ST_POP:  state_next = ST_EVAL;
            ST_EVAL: begin
                if (adj_cnt == 4'd0) begin
                    state_next = ST_SCAN;
                end else if (sp == '0) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_POP;
                end
            end
            ST_SCAN: begin
                // A push on the last neighbour keeps the stack non-empty
                if (nb == 3'd7) begin
                    state_next = (sp == '0 && !scan_push) ? ST_DONE : ST_POP;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Stack storage needs no reset; the pointer alone defines its contents
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_mem[IDX_W'(sp)] <= push_idx;
        end
    end

    // Datapath: stack pointer, queued guard, current cell, neighbour counter, reveal map and bomb flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            sp          <= '0;
            queued      <= '0;
            cur         <= '0;
            nb          <= 3'd0;
            reveal_grid <= '0;
            hit_bomb    <= 1'b0;
        end else begin
            if (push_en) begin
                sp               <= sp + CW'(1);
                queued[push_idx] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        reveal_grid <= '0;
                        hit_bomb    <= 1'b0;
                    end else if (start && !reveal_grid[start_idx] && bomb_grid[start_idx]) begin
                        reveal_grid[start_idx] <= 1'b1;
                        hit_bomb               <= 1'b1;
                    end
                end
                ST_POP: begin
                    sp                             <= sp_top;
                    cur                            <= stack_mem[sp_top];
                    reveal_grid[stack_mem[sp_top]] <= 1'b1;
                end
                ST_EVAL: nb <= 3'd0;
                ST_SCAN: nb <= nb + 3'd1;
                ST_DONE: queued <= '0;
                default: ;
            endcase
        end
    end

`ifdef MINES_WIN_DETECT_EN
    logic [CW-1:0] reveal_cnt;
    logic [CW-1:0] bomb_cnt;

    // Bomb population of the current map
    always_comb begin
        bomb_cnt = '0;
        for (int i = 0; i < N; i++) begin
            bomb_cnt = bomb_cnt + CW'(bomb_grid[i]);
        end
    end

    // Count reveals and latch win when every safe cell is open without a bomb hit
    always_ff @(posedge clock) begin
        if (!reset) begin
            reveal_cnt <= '0;
            win        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        reveal_cnt <= '0;
                        win        <= 1'b0;
                    end else if (start && !reveal_grid[start_idx] && bomb_grid[start_idx]) begin
                        reveal_cnt <= reveal_cnt + CW'(1);
                    end
                end
                ST_POP:  reveal_cnt <= reveal_cnt + CW'(1);
                ST_DONE: begin
                    if (!hit_bomb && reveal_cnt == CW'(N) - bomb_cnt) begin
                        win <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_reveal_sequencer.sv
// tb/tb_reveal_sequencer.sv - scoreboard bench for reveal_sequencer on a 3x3 board
module tb_reveal_sequencer;

    localparam int GS = 3;
    localparam int N  = GS * GS;
    localparam int IW = 4;

    typedef struct {
        logic [N-1:0] grid;
        logic         hit;
        logic         win;
        int           lat;
        logic         chk_busy;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] start_idx;
    logic          clear;
    logic [N-1:0]  bomb_grid;
    logic [N-1:0]  reveal_grid;
    logic          busy;
    logic          done;
    logic          hit_bomb;
`ifdef MINES_WIN_DETECT_EN
    logic          win;
`endif

    int            total = 0;
    int            bad   = 0;
    exp_t          sb[$];
    logic [N-1:0]  m_grid;
    logic          m_hit;
    logic          m_win;

    reveal_sequencer #(
        .GRID_SIZE   (GS),
        .IDX_W       (IW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_idx   (start_idx),
        .clear       (clear),
        .bomb_grid   (bomb_grid),
        .reveal_grid (reveal_grid),
        .busy        (busy),
        .done        (done),
        .hit_bomb    (hit_bomb)
`ifdef MINES_WIN_DETECT_EN
       ,.win         (win)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int adj(input logic [N-1:0] b, input int idx);
        int n = 0;
        int r = idx / GS;
        int c = idx % GS;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < GS && c + dc >= 0 && c + dc < GS)
                    if (b[(r + dr) * GS + c + dc]) n++;
        return n;
    endfunction

    function automatic int popc(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) n++;
        return n;
    endfunction

    // Reference reveal: fixed-point expansion from the start cell through zero cells
    task automatic model_reveal(input logic [N-1:0] b, input int s, output exp_t e);
        logic [N-1:0] reach;
        bit           changed;
        int           lat;
        e.chk_busy = !b[s];
        if (m_grid[s] || b[s]) begin
            lat = 1;
            if (!m_grid[s]) begin
                m_grid[s] = 1'b1;
                m_hit     = 1'b1;
            end
        end else begin
            reach    = '0;
            reach[s] = 1'b1;
            changed  = 1'b1;
            while (changed) begin
                changed = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (reach[i] && adj(b, i) == 0) begin
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++) begin
                                int r = i / GS + dr;
                                int c = i % GS + dc;
                                if (r >= 0 && r < GS && c >= 0 && c < GS) begin
                                    int j = r * GS + c;
                                    if (!b[j] && !m_grid[j] && !reach[j]) begin
                                        reach[j] = 1'b1;
                                        changed  = 1'b1;
                                    end
                                end
                            end
                    end
                end
            end
            lat = 1;
            for (int i = 0; i < N; i++) if (reach[i]) lat += (adj(b, i) == 0) ? 10 : 2;
            m_grid = m_grid | reach;
        end
        if (!m_hit && popc(m_grid) == N - popc(b)) m_win = 1'b1;
        e.grid = m_grid;
        e.hit  = m_hit;
        e.win  = m_win;
        e.lat  = lat;
    endtask

    task automatic do_reveal(input logic [N-1:0] b, input int s, input int poke_at);
        exp_t e;
        exp_t g;
        int   lat      = 1;
        int   busy_cyc = 0;
        bit   seen     = 0;
        @(negedge clock);
        bomb_grid = b;
        model_reveal(b, s, e);
        sb.push_back(e);
        start     = 1'b1;
        start_idx = IW'(s);
        @(negedge clock);
        start = 1'b0;
        while (lat <= 500) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1;
                break;
            end
            if (lat == poke_at) begin
                start     = 1'b1;
                clear     = 1'b1;
                start_idx = '0;
            end else begin
                start = 1'b0;
                clear = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        clear = 1'b0;
        check_val("done_seen", 32'(seen), 32'd1);
        g = sb.pop_front();
        check_val("done_latency", 32'(lat), 32'(g.lat));
        check_val("reveal_grid", 32'(reveal_grid), 32'(g.grid));
        check_val("hit_bomb", 32'(hit_bomb), 32'(g.hit));
        if (g.chk_busy) check_val("busy_cycles", 32'(busy_cyc), 32'(g.lat));
        @(negedge clock);
        check_val("done_pulse_end", 32'(done), 32'd0);
        check_val("busy_after", 32'(busy), 32'd0);
`ifdef MINES_WIN_DETECT_EN
        check_val("win", 32'(win), 32'(g.win));
`endif
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear  = 1'b0;
        m_grid = '0;
        m_hit  = 1'b0;
        m_win  = 1'b0;
        check_val("clear_grid", 32'(reveal_grid), 32'd0);
        check_val("clear_hit", 32'(hit_bomb), 32'd0);
`ifdef MINES_WIN_DETECT_EN
        check_val("clear_win", 32'(win), 32'd0);
`endif
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        start_idx = '0;
        clear     = 1'b0;
        bomb_grid = '0;
        m_grid    = '0;
        m_hit     = 1'b0;
        m_win     = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_grid", 32'(reveal_grid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_hit", 32'(hit_bomb), 32'd0);
        reset = 1'b1;

        // Empty board, centre start: whole board in 91 cycles
        do_reveal(9'h000, 4, 0);
        check_val("full_grid_const", 32'(reveal_grid), 32'h1FF);
        do_clear();

        // Bomb at 0, start at far corner
        do_reveal(9'h001, 8, 0);
        check_val("corner_grid_const", 32'(reveal_grid), 32'h1FE);
        do_clear();

        // Direct bomb hit
        do_reveal(9'h001, 0, 0);
        check_val("hit_const", 32'(hit_bomb), 32'd1);
        do_clear();

        // Numbered start cell, then the same cell again
        do_reveal(9'h001, 4, 0);
        check_val("numbered_grid_const", 32'(reveal_grid), 32'h010);
        do_reveal(9'h001, 4, 0);
        do_clear();

        // No wrap between column 0 and column 2
        do_reveal(9'h020, 6, 0);
        check_val("wrap_grid_const", 32'(reveal_grid), 32'h0DB);
        do_clear();

        // start/clear pulsed while busy must be ignored
        do_reveal(9'h000, 4, 20);
        do_clear();

        // Reset in the middle of a flood
        @(negedge clock);
        bomb_grid = '0;
        start     = 1'b1;
        start_idx = IW'(4);
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check_val("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_grid", 32'(reveal_grid), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        reset  = 1'b1;
        m_grid = '0;
        m_hit  = 1'b0;
        m_win  = 1'b0;
        do_reveal(9'h000, 0, 0);
        do_clear();

        // Random sparse boards, two reveals each
        for (int t = 0; t < 8; t++) begin
            logic [N-1:0] b;
            b = N'($urandom) & N'($urandom) & N'($urandom);
            do_reveal(b, $urandom_range(0, N - 1), 0);
            do_reveal(b, $urandom_range(0, N - 1), 0);
            do_clear();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
